pc_unit: RTL and testbench

Parametrised fetch program-counter unit for the Neko-V core, replacing the fixed 32-bit counter. It holds the architectural fetch PC and supports sequential advance (4-byte, or 2-byte with the C extension), absolute and PC-relative redirects, call/return through a small return-address stack (RAS), trap entry with EPC capture, and `mret`. Fetch reads `pc`; execute drives redirects; the trap logic drives `trap_*` and `mret_valid`.

---
 rtl/neko_pc_pkg.sv | 16 +
 rtl/pc_ras.sv | 70 +++++++
 rtl/pc_unit.sv | 119 +++++++++++
 tb/tb_pc_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/neko_pc_pkg.sv
// Shared types and constants for the Neko-V fetch PC unit.
//   redirect_mode_t : encoding of the redirect_mode input
//   STEP_32/STEP_16 : sequential step sizes in bytes
package neko_pc_pkg;

    typedef enum logic [1:0] {
        SET  = 2'd0,
        REL  = 2'd1,
        CALL = 2'd2,
        RET  = 2'd3
    } redirect_mode_t;

    localparam int unsigned STEP_32 = 4;
    localparam int unsigned STEP_16 = 2;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack with saturating occupancy count.
//   clk, reset : clock, synchronous active-high reset
//   push, data : write data as the new top (overwrites oldest when full)
//   pop        : drop the top entry (ignored when empty)
//   top        : current top entry (undefined when empty)
//   empty/full : registered occupancy flags
module pc_ras #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]  entries [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;        // next slot to write; top is ptr-1
    logic [PTR_W-1:0] ptr_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [PTR_W-1:0] top_idx;

    assign top_idx = ptr - PTR_W'(1);
    assign top     = entries[top_idx];

    // Pointer/count update; push and pop are mutually exclusive at the caller.
    always_comb begin
        ptr_next   = ptr;
        count_next = count;
        if (push) begin
            ptr_next = ptr + PTR_W'(1);
            if (count != CNT_W'(RAS_DEPTH)) begin
                count_next = count + CNT_W'(1);
            end
        end else if (pop && (count != '0)) begin
            ptr_next   = ptr - PTR_W'(1);
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            ptr   <= ptr_next;
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == CNT_W'(RAS_DEPTH));
        end
    end

    // Storage carries no reset; contents are meaningless while count is 0.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            entries[ptr] <= data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch program-counter unit: sequential advance, redirects (SET/REL/CALL/RET),
// trap entry with EPC capture, and mret.
//   clk, reset          : clock, synchronous active-high reset
//   stall, advance      : sequential advance when advance && !stall
//   is_compressed       : 2-byte step (only with C_EXT)
//   redirect_*          : redirect request from execute
//   trap_valid/vector/epc, mret_valid : trap logic
//   pc, epc             : fetch PC and saved exception PC
//   misaligned          : one-cycle pulse for a rejected redirect
//   ras_empty, ras_full : return-address stack occupancy
module pc_unit
    import neko_pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     RAS_DEPTH    = 4,
    parameter bit              C_EXT        = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            advance,
    input  logic            is_compressed,
    input  logic            redirect_valid,
    input  logic [1:0]      redirect_mode,
    input  logic [XLEN-1:0] redirect_base,
    input  logic [XLEN-1:0] redirect_data,
    input  logic            redirect_len2,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic [XLEN-1:0] trap_epc,
    input  logic            mret_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] epc,
    output logic            misaligned,
    output logic            ras_empty,
    output logic            ras_full
);

    redirect_mode_t  mode;
    logic [XLEN-1:0] ras_top;
    logic            ras_push;
    logic            ras_pop;
    logic [XLEN-1:0] step;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] target;
    logic            aligned;
    logic            redirect_win;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] epc_next;
    logic            misaligned_next;

    assign mode = redirect_mode_t'(redirect_mode);

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .data  (link),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

    // Target selection, alignment check and the trap > mret > redirect > advance mux.
    always_comb begin
        step            = (C_EXT && is_compressed) ? XLEN'(STEP_16) : XLEN'(STEP_32);
        link            = redirect_base + (redirect_len2 ? XLEN'(STEP_16) : XLEN'(STEP_32));
        target          = redirect_data;
        pc_next         = pc;
        epc_next        = epc;
        misaligned_next = 1'b0;

        case (mode)
            SET:       target = redirect_data;
            REL, CALL: target = redirect_base + redirect_data;
            RET:       target = ras_empty ? redirect_data : ras_top;
            default:   target = redirect_data;
        endcase

        aligned      = C_EXT ? (target[0] == 1'b0) : (target[1:0] == 2'b00);
        redirect_win = redirect_valid && !trap_valid && !mret_valid;
        // A rejected or losing redirect must leave the RAS untouched.
        ras_push     = redirect_win && aligned && (mode == CALL);
        ras_pop      = redirect_win && aligned && (mode == RET) && !ras_empty;

        if (trap_valid) begin
            pc_next  = trap_vector & ~XLEN'(3);
            epc_next = trap_epc;
        end else if (mret_valid) begin
            pc_next = epc;
        end else if (redirect_valid) begin
            if (aligned) begin
                pc_next = target;
            end else begin
                misaligned_next = 1'b1;
            end
        end else if (advance && !stall) begin
            pc_next = pc + step;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_VECTOR;
            epc        <= '0;
            misaligned <= 1'b0;
        end else begin
            pc         <= pc_next;
            epc        <= epc_next;
            misaligned <= misaligned_next;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: one instance without and one with the C extension
// share the same stimulus; a queue-based reference model predicts each cycle.
module tb_pc_unit;

    typedef logic [31:0] word_t;
    typedef word_t word_q_t[$];

    typedef struct {
        bit    reset;
        bit    stall;
        bit    advance;
        bit    is_compressed;
        bit    redirect_valid;
        bit [1:0] mode;
        word_t base;
        word_t data;
        bit    len2;
        bit    trap_valid;
        word_t trap_vector;
        word_t trap_epc;
        bit    mret_valid;
    } stim_t;

    typedef struct packed {
        word_t pc;
        word_t epc;
        logic  mis;
        logic  empty;
        logic  full;
    } obs_t;

    localparam word_t RV    = 32'h100;
    localparam int    DEPTH = 4;

    logic  clk = 1'b0;
    logic  reset, stall, advance, is_compressed, redirect_valid, redirect_len2;
    logic  trap_valid, mret_valid;
    logic [1:0] redirect_mode;
    word_t redirect_base, redirect_data, trap_vector, trap_epc;

    word_t pc0, epc0, pc1, epc1;
    logic  mis0, empty0, full0, mis1, empty1, full1;

    always #5 clk = ~clk;

    pc_unit #(.XLEN(32), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH), .C_EXT(1'b0)) u_dut32 (
        .clk(clk), .reset(reset), .stall(stall), .advance(advance),
        .is_compressed(is_compressed), .redirect_valid(redirect_valid),
        .redirect_mode(redirect_mode), .redirect_base(redirect_base),
        .redirect_data(redirect_data), .redirect_len2(redirect_len2),
        .trap_valid(trap_valid), .trap_vector(trap_vector), .trap_epc(trap_epc),
        .mret_valid(mret_valid), .pc(pc0), .epc(epc0), .misaligned(mis0),
        .ras_empty(empty0), .ras_full(full0)
    );

    pc_unit #(.XLEN(32), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH), .C_EXT(1'b1)) u_dutc (
        .clk(clk), .reset(reset), .stall(stall), .advance(advance),
        .is_compressed(is_compressed), .redirect_valid(redirect_valid),
        .redirect_mode(redirect_mode), .redirect_base(redirect_base),
        .redirect_data(redirect_data), .redirect_len2(redirect_len2),
        .trap_valid(trap_valid), .trap_vector(trap_vector), .trap_epc(trap_epc),
        .mret_valid(mret_valid), .pc(pc1), .epc(epc1), .misaligned(mis1),
        .ras_empty(empty1), .ras_full(full1)
    );

    obs_t exp_q0[$];
    obs_t exp_q1[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state per instance.
    word_t   m_pc0, m_epc0, m_pc1, m_epc1;
    bit      m_mis0, m_mis1;
    word_q_t ras0, ras1;

    // Architectural behaviour of one cycle; the RAS is a bounded LIFO queue.
    task automatic model_step(input bit cext, input stim_t s, inout word_t pc, inout word_t epc,
                              inout bit mis, inout word_q_t ras);
        word_t tgt;
        bit    ok;
        mis = 1'b0;
        if (s.reset) begin
            pc  = RV;
            epc = 32'h0;
            ras = {};
        end else if (s.trap_valid) begin
            pc  = {s.trap_vector[31:2], 2'b00};
            epc = s.trap_epc;
        end else if (s.mret_valid) begin
            pc = epc;
        end else if (s.redirect_valid) begin
            if (s.mode == 2'd0)      tgt = s.data;
            else if (s.mode == 2'd3) tgt = (ras.size() > 0) ? ras[ras.size()-1] : s.data;
            else                     tgt = s.base + s.data;
            ok = cext ? (tgt % 2 == 0) : (tgt % 4 == 0);
            if (!ok) begin
                mis = 1'b1;
            end else begin
                pc = tgt;
                if (s.mode == 2'd2) begin
                    ras.push_back(s.base + (s.len2 ? 32'd2 : 32'd4));
                    if (ras.size() > DEPTH) void'(ras.pop_front());
                end
                if (s.mode == 2'd3 && ras.size() > 0) void'(ras.pop_back());
            end
        end else if (s.advance && !s.stall) begin
            pc = pc + ((cext && s.is_compressed) ? 32'd2 : 32'd4);
        end
    endtask

    task automatic step(input stim_t s);
        @(negedge clk);
        reset          = s.reset;
        stall          = s.stall;
        advance        = s.advance;
        is_compressed  = s.is_compressed;
        redirect_valid = s.redirect_valid;
        redirect_mode  = s.mode;
        redirect_base  = s.base;
        redirect_data  = s.data;
        redirect_len2  = s.len2;
        trap_valid     = s.trap_valid;
        trap_vector    = s.trap_vector;
        trap_epc       = s.trap_epc;
        mret_valid     = s.mret_valid;
        model_step(1'b0, s, m_pc0, m_epc0, m_mis0, ras0);
        model_step(1'b1, s, m_pc1, m_epc1, m_mis1, ras1);
        exp_q0.push_back('{pc: m_pc0, epc: m_epc0, mis: m_mis0,
                           empty: (ras0.size() == 0), full: (ras0.size() == DEPTH)});
        exp_q1.push_back('{pc: m_pc1, epc: m_epc1, mis: m_mis1,
                           empty: (ras1.size() == 0), full: (ras1.size() == DEPTH)});
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.reset = 0; s.stall = 0; s.advance = 0; s.is_compressed = 0;
        s.redirect_valid = 0; s.mode = 2'd0; s.base = 0; s.data = 0; s.len2 = 0;
        s.trap_valid = 0; s.trap_vector = 0; s.trap_epc = 0; s.mret_valid = 0;
        return s;
    endfunction

    function automatic stim_t redir(input bit [1:0] m, input word_t b, input word_t d);
        stim_t s = idle();
        s.redirect_valid = 1'b1;
        s.mode = m;
        s.base = b;
        s.data = d;
        return s;
    endfunction

    task automatic check(input int inst, input obs_t act, input obs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL inst%0d vec%0d: got pc=%h epc=%h mis=%b empty=%b full=%b, want pc=%h epc=%h mis=%b empty=%b full=%b",
                     inst, vectors, act.pc, act.epc, act.mis, act.empty, act.full,
                     exp.pc, exp.epc, exp.mis, exp.empty, exp.full);
        end
    endtask

    // Monitor: outputs settle just after the edge that consumed the oldest stimulus.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q0.size() > 0) check(0, {pc0, epc0, mis0, empty0, full0}, exp_q0.pop_front());
            if (exp_q1.size() > 0) check(1, {pc1, epc1, mis1, empty1, full1}, exp_q1.pop_front());
        end
    end

    initial begin
        stim_t s;
        int    r;

        s = idle(); s.reset = 1'b1;
        step(s);
        step(idle());

        // Sequential advance, compressed on the C instance.
        s = idle(); s.advance = 1'b1; s.is_compressed = 1'b1;
        repeat (3) step(s);

        // Relative redirects, including one misaligned only without C.
        step(redir(2'd0, 0, 32'h200));
        step(redir(2'd1, 32'h1F0, -32'sd16));
        step(redir(2'd1, 32'h1F0, 32'h6));
        step(idle());
        step(idle());

        // CALL/RET round trip, then RET on an empty stack.
        step(redir(2'd0, 0, 32'h40));
        step(redir(2'd2, 32'h40, 32'h40));
        step(redir(2'd3, 0, 32'h0));
        step(redir(2'd3, 0, 32'h300));

        // Overflow: five calls, then drain past empty.
        for (int i = 0; i < 5; i++) begin
            s = redir(2'd2, 32'h1000 + 32'(i * 16), 32'h100);
            s.len2 = (i == 2);
            step(s);
        end
        for (int i = 0; i < 5; i++) step(redir(2'd3, 0, 32'h700));

        // Trap beats redirect and advance; then mret.
        step(redir(2'd2, 32'h40, 32'h40));
        s = redir(2'd2, 32'h80, 32'h20);
        s.advance = 1'b1; s.trap_valid = 1'b1; s.trap_vector = 32'h803; s.trap_epc = 32'h50;
        step(s);
        s = idle(); s.mret_valid = 1'b1;
        step(s);

        // Stall only blocks advance; wrap at the top of the address space.
        s = idle(); s.stall = 1'b1; s.advance = 1'b1;
        step(s);
        s = redir(2'd0, 0, 32'h400); s.stall = 1'b1;
        step(s);
        step(redir(2'd0, 0, 32'hFFFF_FFFC));
        s = idle(); s.advance = 1'b1;
        step(s);

        // Reset in the middle of activity.
        step(redir(2'd2, 32'h20, 32'h100));
        s = idle(); s.trap_valid = 1'b1; s.trap_vector = 32'h900; s.trap_epc = 32'h64;
        step(s);
        s = redir(2'd2, 32'h30, 32'h100); s.reset = 1'b1;
        step(s);
        step(idle());

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            s = idle();
            s.reset          = ($urandom_range(63) == 0);
            s.stall          = ($urandom_range(3) == 0);
            s.advance        = ($urandom_range(1) == 1);
            s.is_compressed  = ($urandom_range(1) == 1);
            s.redirect_valid = ($urandom_range(2) == 0);
            s.mode           = 2'($urandom_range(3));
            s.base           = ($urandom_range(1) == 1) ? m_pc0 : $urandom();
            r = $urandom_range(7);
            s.data           = $urandom();
            if (r < 5)       s.data = s.data & ~32'h3;
            else if (r < 7)  s.data = s.data & ~32'h1;
            if ($urandom_range(3) == 0) s.data = s.data & 32'hFF;
            s.len2           = ($urandom_range(1) == 1);
            s.trap_valid     = ($urandom_range(19) == 0);
            s.trap_vector    = $urandom();
            s.trap_epc       = $urandom();
            s.mret_valid     = ($urandom_range(15) == 0);
            step(s);
        end

        step(idle());
        @(posedge clk);
        #3;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d/%0d expectations left unchecked, want 0/0",
                     exp_q0.size(), exp_q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
